// File: rtl/tick_period_sel_if.sv
// tick_period_sel control/status bundle.
// Master drives enable and mode request; slave returns tick, wave and mode status.
interface tick_period_sel_if #(
  parameter int SEL_W = 2
);
  logic             on_off;
  logic [SEL_W-1:0] sel;
  logic             tick_o;
  logic             wave_o;
  logic [SEL_W-1:0] active_sel_o;
  logic             pending_o;

  modport master (
    output on_off,
    output sel,
    input  tick_o,
    input  wave_o,
    input  active_sel_o,
    input  pending_o
  );

  modport slave (
    input  on_off,
    input  sel,
    output tick_o,
    output wave_o,
    output active_sel_o,
    output pending_o
  );
endinterface

// File: rtl/tick_period_sel.sv
// Selectable-period tick generator with boundary-aligned mode switching.
// Base tick from a prescaler, period 2^(mode+1) base ticks, last mode stops.
module tick_period_sel #(
  parameter int BASE_DIV = 50_000_000,
  parameter int N_MODES  = 4,
  parameter int SEL_W    = 2
) (
  input  logic            clk,
  input  logic            rst,
  tick_period_sel_if.slave bus
);
  localparam int PRE_W = $clog2(BASE_DIV);
  localparam int CNT_W = N_MODES - 1;
  localparam logic [SEL_W-1:0] STOP = SEL_W'(N_MODES - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BASE_DIV - 1);

  logic [PRE_W-1:0] presc_q;
  logic [CNT_W-1:0] pcnt_q;
  logic             tick_q;
  logic             wave_q;
  logic [SEL_W-1:0] act_q;
  logic             pend_q;

  logic [SEL_W-1:0] eff_sel;
  logic [CNT_W-1:0] pcnt_last;
  logic             running;
  logic             base_tick;
  logic             boundary;

  // Out-of-range requests collapse onto the stopped mode.
  always_comb begin
    eff_sel = bus.sel;
    if (32'(bus.sel) >= N_MODES)
      eff_sel = STOP;
  end

  // Terminal count 2^(act+1)-1 is simply act+1 low ones.
  always_comb begin
    pcnt_last = '0;
    for (int i = 0; i < CNT_W; i++)
      if (i <= int'(act_q))
        pcnt_last[i] = 1'b1;
  end

  assign running   = bus.on_off && (act_q != STOP);
  assign base_tick = running && (presc_q == PRE_LAST);
  assign boundary  = base_tick && (pcnt_q == pcnt_last);

  // Prescaler: free count while running, parked at zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      presc_q <= '0;
    else if (!running || base_tick)
      presc_q <= '0;
    else
      presc_q <= presc_q + PRE_W'(1);
  end

  // Period counter: advances per base tick, restarts at each boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pcnt_q <= '0;
    else if (!running || boundary)
      pcnt_q <= '0;
    else if (base_tick)
      pcnt_q <= pcnt_q + CNT_W'(1);
  end

  // Mode register: immediate load when idle, boundary-only load when running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q  <= STOP;
      pend_q <= 1'b0;
    end else if (!running || boundary) begin
      act_q  <= eff_sel;
      pend_q <= 1'b0;
    end else begin
      pend_q <= (eff_sel != act_q);
    end
  end

  // Tick pulse and square wave; enable low clears the wave, stop holds it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= 1'b0;
      wave_q <= 1'b0;
    end else begin
      tick_q <= boundary;
      if (!bus.on_off)
        wave_q <= 1'b0;
      else if (boundary)
        wave_q <= ~wave_q;
    end
  end

  assign bus.tick_o       = tick_q;
  assign bus.wave_o       = wave_q;
  assign bus.active_sel_o = act_q;
  assign bus.pending_o    = pend_q;
endmodule
